mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch path (I) and the load/store path (D) of the multicycle core.
- Sits between the processing datapath's IMemRead/DMemOp request points and the physical memory.
- Serialises accesses, arbitrates round-robin, inserts the memory's fixed read latency, and returns read data with a one-cycle valid pulse.
- Lets the control FSM stall on explicit handshakes instead of fixed wait states.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 64, data width; must be a multiple of 8.
- MEM_LAT, 1, memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request
- i_addr  in  ADDR_W  instruction address
- i_gnt  out  1  instruction request accepted this cycle
- i_rvalid  out  1  i_rdata valid, one-cycle pulse
- i_rdata  out  DATA_W  instruction read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  DATA_W/8  byte-enable mask for stores
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid, one-cycle pulse; loads only
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle of a read
- busy  out  1  arbiter is not IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, lat_cnt = 0, last_grant = D (so I wins the first tie).
  - All gnt, rvalid, mem_en, mem_we and busy outputs = 0.
  - Reset mid-read discards the in-flight transaction; no rvalid is ever issued for it.
- State machine with states IDLE, READ_WAIT, READ_RESP.
- IDLE:
  - If no request: all strobes 0.
  - Winner selection: if only one requester is asserted, it wins. If both, the one not equal to last_grant wins.
  - In the same cycle (combinational):
    - winner's gnt = 1, mem_en = 1, mem_addr = winner address.
    - For D: mem_we = d_we, mem_wdata = d_wdata, mem_wmask = d_wmask.
    - For I: mem_we = 0, mem_wmask = 0.
  - last_grant <= winner.
  - D store: transaction complete; remain in IDLE, so a new grant is possible next cycle. No d_rvalid.
  - Any read: if MEM_LAT == 1 go to READ_RESP, else go to READ_WAIT with lat_cnt <= MEM_LAT-1.
  - owner register <= winner.
- READ_WAIT: lat_cnt decrements each cycle; at lat_cnt == 1 go to READ_RESP. No grants issued.
- READ_RESP:
  - owner's rvalid = 1 and owner's rdata = mem_rdata, passed through combinationally.
  - Non-owner rdata = 0.
  - Next state IDLE; no grant in this cycle.
- Throughput and latency:
  - Read occupancy = MEM_LAT+1 cycles from grant to rvalid inclusive; the next grant can occur the cycle after rvalid.
  - Store occupancy = 1 cycle.
- Requester rules:
  - Requesters hold req and address/data stable until gnt.
  - Deasserting req before gnt is legal and has no side effect.
  - A request held asserted after gnt is treated as a new request in the next IDLE cycle.
- Starvation: with both requests held continuously, grants strictly alternate I, D, I, D, …
- busy = 1 in READ_WAIT and READ_RESP.

Decomposition:
- New package memory_types:
  - typedef enum arb_state_t {IDLE, READ_WAIT, READ_RESP}
  - typedef enum requester_t {REQ_I, REQ_D}
  - localparam MAX_MEM_LAT = 4
- One sub-module arb_rr2: two-input round-robin pick, fully combinational from (i_req, d_req, last_grant), output winner and any.
- Latency counter and FSM stay in mem_port_arbiter.

Test Plan:
- I-only read, MEM_LAT=1, i_addr=0x40, memory word 0x00500093 -> i_gnt in cycle 0, i_rvalid in cycle 1 with i_rdata=0x00500093, busy=1 in cycle 1 only.
- Simultaneous i_req and d_req (load 0x100) held from reset -> grant order I, D, I, D; each rvalid goes only to the owner; the other rdata = 0.
- D store d_addr=0x200, d_wdata=0xDEADBEEF, d_wmask=0x0F, followed by a D load of 0x200 -> store granted cycle 0 with no rvalid; load granted cycle 1; d_rdata lower word = 0xDEADBEEF.
- MEM_LAT=3 read of 0x80 -> d_rvalid exactly 3 cycles after d_gnt; d_gnt stays 0 for a competing request until the cycle after rvalid.
- reset asserted in READ_WAIT (MEM_LAT=3) -> outputs 0 immediately (asynchronous), no rvalid afterwards, first post-reset tie granted to I.
- d_req raised then dropped while an I read is in flight -> no d_gnt, no memory write.

Source files
------------

// File: rtl/memory_types.sv
// Shared types for the unified-memory port arbiter.
//   arb_state_t  : arbiter FSM states
//   requester_t  : identifies the instruction (I) or load/store (D) requester
//   MAX_MEM_LAT  : largest supported memory read latency
//   LAT_CNT_W    : width of the read-latency down-counter
package memory_types;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } requester_t;

    localparam int MAX_MEM_LAT = 4;
    localparam int LAT_CNT_W   = $clog2(MAX_MEM_LAT + 1);

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin pick between the I and D requesters.
// Purely combinational.
//   i_req_i      : instruction requester active
//   d_req_i      : data requester active
//   last_grant_i : requester that won the previous grant
//   winner_o     : selected requester (meaningful only when any_o = 1)
//   any_o        : at least one requester is active
module arb_rr2
    import memory_types::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  requester_t last_grant_i,
    output requester_t winner_o,
    output logic       any_o
);

    // NOTE: every output gets a value on every path through this block,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        any_o    = i_req_i | d_req_i;
        winner_o = REQ_I;
        if (i_req_i && d_req_i) begin
            // On a tie the requester that did not win last time goes first.
            winner_o = (last_grant_i == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req_i) begin
            winner_o = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between the instruction-fetch
// path (I) and the load/store path (D). Accesses are serialised with a
// round-robin pick, the memory's fixed read latency is absorbed by the
// FSM, and read data comes back with a one-cycle valid pulse.
//   clk, reset           : clock, asynchronous active-high reset
//   i_req/i_addr         : instruction read request and address
//   i_gnt                : instruction request accepted this cycle
//   i_rvalid/i_rdata     : instruction read data, one-cycle pulse
//   d_req/d_we/d_addr    : data request, store select, address
//   d_wdata/d_wmask      : store data and byte enables
//   d_gnt                : data request accepted this cycle
//   d_rvalid/d_rdata     : load data, one-cycle pulse (loads only)
//   mem_*                : physical memory port; mem_rdata is valid
//                          MEM_LAT cycles after the mem_en cycle of a read
//   busy                 : a read is in flight (arbiter not idle)
module mem_port_arbiter
    import memory_types::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..%0d", MAX_MEM_LAT);
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("mem_port_arbiter: DATA_W must be a multiple of 8");
    end

    arb_state_t           state_q, state_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    requester_t           last_grant_q, last_grant_d;
    requester_t           owner_q, owner_d;
    logic                 rvalid_q;
    logic                 busy_q;

    requester_t           winner;
    logic                 any_req;
    logic                 grant;
    logic                 is_store;

    arb_rr2 u_rr (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .any_o        (any_req)
    );

    // Grants happen only from IDLE, and never while reset is held, so a
    // requester cannot see a stray gnt during reset.
    assign grant    = (state_q == IDLE) && any_req && !reset;
    assign is_store = (winner == REQ_D) && d_we;

    assign i_gnt     = grant && (winner == REQ_I);
    assign d_gnt     = grant && (winner == REQ_D);
    assign mem_en    = grant;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = (winner == REQ_D) ? d_addr : i_addr;
    assign mem_wdata = d_gnt ? d_wdata : '0;
    assign mem_wmask = d_gnt ? d_wmask : '0;

    // Response data is a straight pass-through of the memory; only the owner
    // of the in-flight read sees it, the other side reads zero.
    assign i_rvalid = rvalid_q && (owner_q == REQ_I);
    assign d_rvalid = rvalid_q && (owner_q == REQ_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;
    assign busy     = busy_q;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    last_grant_d = winner;
                    owner_d      = winner;
                    // A store finishes in its grant cycle; only reads wait.
                    if (!is_store) begin
                        if (MEM_LAT == 1) begin
                            state_d = READ_RESP;
                        end else begin
                            state_d   = READ_WAIT;
                            lat_cnt_d = LAT_CNT_W'(MEM_LAT - 1);
                        end
                    end
                end
            end
            READ_WAIT: begin
                lat_cnt_d = lat_cnt_q - 1'b1;
                if (lat_cnt_q == LAT_CNT_W'(1)) begin
                    state_d = READ_RESP;
                end
            end
            READ_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            last_grant_q <= REQ_D;
            owner_q      <= REQ_I;
            rvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            // Registered copies of the next state's decodes keep the
            // valid pulse and busy flag glitch-free.
            rvalid_q     <= (state_d == READ_RESP);
            busy_q       <= (state_d != IDLE);
        end
    end

endmodule
